// File: rtl/wb_stage.sv
// wb_stage: writeback stage feeding the register file write port.
//   Accepts execute results over ex_valid/ex_ready. Non-load results are
//   committed the next cycle. Loads park in WAIT_MEM until mem_resp_valid,
//   then the byte/halfword/word is extracted and committed. A load with no
//   response for TIMEOUT cycles is abandoned and sets sticky err_timeout.
// Ports:
//   clk, rst (async, active-low)
//   ex_*            execute result handshake and fields
//   mem_resp_*      single-cycle memory response
//   reg_dest/data/regWEn   registered regfile write port (regWEn one-cycle pulse)
//   byp_*           combinational copies of the write port for decode bypass
//   busy_valid/rd   outstanding load indication
//   err_timeout     sticky load-timeout flag
module wb_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [4:0]  ex_rd,
    input  logic        ex_wen,
    input  logic        ex_is_load,
    input  logic [2:0]  ex_funct3,
    input  logic [1:0]  ex_addr_lo,
    input  logic [31:0] ex_alu_result,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic [4:0]  reg_dest,
    output logic [31:0] data,
    output logic        regWEn,
    output logic        byp_valid,
    output logic [4:0]  byp_rd,
    output logic [31:0] byp_data,
    output logic        busy_valid,
    output logic [4:0]  busy_rd,
    output logic        err_timeout
);

    typedef enum logic {
        IDLE,
        WAIT_MEM
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [4:0]  rd_q, rd_d;
    logic        wen_q, wen_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  alo_q, alo_d;
    logic [4:0]  dest_q, dest_d;
    logic [31:0] data_q, data_d;
    logic        we_q, we_d;
    logic        err_q, err_d;

    // Load data extraction; reserved funct3 encodings fall through to LW.
    function automatic logic [31:0] extract(input logic [2:0]  f3,
                                            input logic [1:0]  alo,
                                            input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{alo, 3'b000} +: 8];
        h = alo[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  extract = {{24{b[7]}}, b};
            3'b100:  extract = {24'b0, b};
            3'b001:  extract = {{16{h[15]}}, h};
            3'b101:  extract = {16'b0, h};
            default: extract = w;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        wen_d   = wen_q;
        f3_d    = f3_q;
        alo_d   = alo_q;
        dest_d  = dest_q;
        data_d  = data_q;
        we_d    = 1'b0;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    if (ex_is_load) begin
                        rd_d    = ex_rd;
                        wen_d   = ex_wen;
                        f3_d    = ex_funct3;
                        alo_d   = ex_addr_lo;
                        cnt_d   = '0;
                        state_d = WAIT_MEM;
                    end else begin
                        dest_d = ex_rd;
                        data_d = ex_alu_result;
                        we_d   = ex_wen & (ex_rd != 5'd0);
                    end
                end
            end
            WAIT_MEM: begin
                // A response on the final wait cycle takes priority over timeout.
                if (mem_resp_valid) begin
                    dest_d  = rd_q;
                    data_d  = extract(f3_q, alo_q, mem_resp_data);
                    we_d    = wen_q & (rd_q != 5'd0);
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rd_q    <= '0;
            wen_q   <= 1'b0;
            f3_q    <= '0;
            alo_q   <= '0;
            dest_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wen_q   <= wen_d;
            f3_q    <= f3_d;
            alo_q   <= alo_d;
            dest_q  <= dest_d;
            data_q  <= data_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end

    assign ex_ready    = (state_q == IDLE);
    assign busy_valid  = (state_q == WAIT_MEM);
    assign busy_rd     = rd_q;
    assign reg_dest    = dest_q;
    assign data        = data_q;
    assign regWEn      = we_q;
    assign byp_valid   = we_q;
    assign byp_rd      = dest_q;
    assign byp_data    = data_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage (TIMEOUT=16).
// Inputs are driven just after the falling edge; outputs are sampled on
// the falling edge, i.e. half a cycle after the rising edge that set them.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_rd;
    logic        ex_wen;
    logic        ex_is_load;
    logic [2:0]  ex_funct3;
    logic [1:0]  ex_addr_lo;
    logic [31:0] ex_alu_result;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic [4:0]  reg_dest;
    logic [31:0] data;
    logic        regWEn;
    logic        byp_valid;
    logic [4:0]  byp_rd;
    logic [31:0] byp_data;
    logic        busy_valid;
    logic [4:0]  busy_rd;
    logic        err_timeout;

    int checks = 0;
    int failures = 0;

    wb_stage #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_wen(ex_wen),
        .ex_is_load(ex_is_load), .ex_funct3(ex_funct3), .ex_addr_lo(ex_addr_lo),
        .ex_alu_result(ex_alu_result),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .reg_dest(reg_dest), .data(data), .regWEn(regWEn),
        .byp_valid(byp_valid), .byp_rd(byp_rd), .byp_data(byp_data),
        .busy_valid(busy_valid), .busy_rd(busy_rd), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        ex_valid = 1'b0; ex_rd = '0; ex_wen = 1'b0; ex_is_load = 1'b0;
        ex_funct3 = '0; ex_addr_lo = '0; ex_alu_result = '0;
        mem_resp_valid = 1'b0; mem_resp_data = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({reg_dest, data, regWEn, err_timeout, busy_valid, busy_rd, ex_ready} !==
            {5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1}) begin
            failures++;
            $display("FAIL reset_state got dest=%0d data=%h we=%b err=%b busy=%b brd=%0d rdy=%b exp 0/0/0/0/0/0/1",
                     reg_dest, data, regWEn, err_timeout, busy_valid, busy_rd, ex_ready);
        end
        rst = 1'b1;
    endtask

    task automatic test_alu_write();
        @(negedge clk);
        ex_valid = 1'b1; ex_is_load = 1'b0; ex_rd = 5'd5; ex_wen = 1'b1;
        ex_alu_result = 32'hDEADBEEF;
        @(negedge clk);
        idle_inputs();
        checks++;
        if ({regWEn, reg_dest, data, byp_valid, byp_rd, byp_data} !==
            {1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL alu_write got we=%b dest=%0d data=%h byp=%b/%0d/%h exp 1/5/deadbeef",
                     regWEn, reg_dest, data, byp_valid, byp_rd, byp_data);
        end
        @(negedge clk);
        checks++;
        if ({regWEn, reg_dest, data} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL alu_pulse_end got we=%b dest=%0d data=%h exp we=0 hold 5/deadbeef",
                     regWEn, reg_dest, data);
        end
    endtask

    task automatic test_no_write();
        logic seen;
        // rd=0 with wen=1, then rd=7 with wen=0
        for (int k = 0; k < 2; k++) begin
            seen = 1'b0;
            @(negedge clk);
            ex_valid = 1'b1; ex_is_load = 1'b0;
            ex_rd = (k == 0) ? 5'd0 : 5'd7;
            ex_wen = (k == 0);
            ex_alu_result = 32'h1234;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                idle_inputs();
                if (regWEn !== 1'b0) seen = 1'b1;
            end
            checks++;
            if (seen !== 1'b0) begin
                failures++;
                $display("FAIL no_write_%0d got regWEn=1 seen exp 0", k);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k <= 3) begin
                ex_valid = 1'b1; ex_is_load = 1'b0; ex_wen = 1'b1;
                ex_rd = 5'(k); ex_alu_result = 32'hA000_0000 + 32'(k);
            end else begin
                idle_inputs();
            end
            if (k >= 2) begin
                checks++;
                if ({regWEn, reg_dest, data} !== {1'b1, 5'(k - 1), 32'hA000_0000 + 32'(k - 1)}) begin
                    failures++;
                    $display("FAIL b2b_%0d got we=%b dest=%0d data=%h exp 1/%0d/%h",
                             k - 1, regWEn, reg_dest, data, k - 1, 32'hA000_0000 + 32'(k - 1));
                end
            end
        end
        @(negedge clk);
        checks++;
        if (regWEn !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end got we=%b exp 0", regWEn);
        end
    endtask

    task automatic load_case(input string name, input logic [2:0] f3,
                             input logic [1:0] alo, input logic [31:0] exp);
        @(negedge clk);
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd9; ex_wen = 1'b1;
        ex_funct3 = f3; ex_addr_lo = alo; ex_alu_result = 32'h5555_5555;
        @(negedge clk);
        idle_inputs();
        mem_resp_valid = 1'b1; mem_resp_data = 32'h80FF1234;
        @(negedge clk);
        idle_inputs();
        checks++;
        if ({regWEn, reg_dest, data} !== {1'b1, 5'd9, exp}) begin
            failures++;
            $display("FAIL load_%s got we=%b dest=%0d data=%h exp 1/9/%h",
                     name, regWEn, reg_dest, data, exp);
        end
    endtask

    task automatic test_load_extract();
        load_case("lb3",  3'b000, 2'd3, 32'hFFFFFF80);
        load_case("lbu3", 3'b100, 2'd3, 32'h00000080);
        load_case("lh2",  3'b001, 2'd2, 32'hFFFF80FF);
        load_case("lhu0", 3'b101, 2'd0, 32'h00001234);
        load_case("lw",   3'b010, 2'd1, 32'h80FF1234);
        load_case("lb1",  3'b000, 2'd1, 32'h00000012);
        load_case("lbu2", 3'b100, 2'd2, 32'h000000FF);
        load_case("lh3",  3'b001, 2'd3, 32'hFFFF80FF);
        load_case("lhu2", 3'b101, 2'd2, 32'h000080FF);
        load_case("f011", 3'b011, 2'd3, 32'h80FF1234);
    endtask

    task automatic test_load_latency();
        @(negedge clk);
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd9; ex_wen = 1'b1;
        ex_funct3 = 3'b010; ex_addr_lo = 2'd0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            idle_inputs();
            // stray valid while busy must be ignored
            ex_valid = 1'b1; ex_is_load = 1'b0; ex_rd = 5'd3; ex_wen = 1'b1;
            if (c == 3) begin
                mem_resp_valid = 1'b1; mem_resp_data = 32'h0BAD_F00D;
            end
            checks++;
            if ({ex_ready, busy_valid, busy_rd, regWEn} !== {1'b0, 1'b1, 5'd9, 1'b0}) begin
                failures++;
                $display("FAIL lat_busy_c%0d got rdy=%b busy=%b brd=%0d we=%b exp 0/1/9/0",
                         c, ex_ready, busy_valid, busy_rd, regWEn);
            end
        end
        @(negedge clk);
        idle_inputs();
        checks++;
        if ({regWEn, reg_dest, data, ex_ready, busy_valid} !==
            {1'b1, 5'd9, 32'h0BAD_F00D, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL lat_commit got we=%b dest=%0d data=%h rdy=%b busy=%b exp 1/9/0badf00d/1/0",
                     regWEn, reg_dest, data, ex_ready, busy_valid);
        end
    endtask

    task automatic test_timeout();
        int busy_cnt;
        logic saw_we;
        busy_cnt = 0;
        saw_we = 1'b0;
        do_reset();
        @(negedge clk);
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd12; ex_wen = 1'b1;
        ex_funct3 = 3'b010;
        @(negedge clk);
        idle_inputs();
        for (int c = 0; c < 40 && busy_valid; c++) begin
            busy_cnt++;
            @(negedge clk);
            if (regWEn) saw_we = 1'b1;
        end
        checks++;
        if (busy_cnt !== 16) begin
            failures++;
            $display("FAIL timeout_len got busy_cycles=%0d exp 16", busy_cnt);
        end
        checks++;
        if ({err_timeout, saw_we, ex_ready} !== {1'b1, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL timeout_flag got err=%b we_seen=%b rdy=%b exp 1/0/1",
                     err_timeout, saw_we, ex_ready);
        end
        // sticky across later traffic
        load_case("after_to", 3'b010, 2'd0, 32'h80FF1234);
        checks++;
        if (err_timeout !== 1'b1) begin
            failures++;
            $display("FAIL timeout_sticky got err=%b exp 1", err_timeout);
        end
    endtask

    task automatic test_timeout_race();
        do_reset();
        @(negedge clk);
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd14; ex_wen = 1'b1;
        ex_funct3 = 3'b100; ex_addr_lo = 2'd1;
        @(negedge clk);
        idle_inputs();
        // now in the 1st WAIT_MEM cycle; advance to the 16th
        for (int c = 1; c < 16; c++) @(negedge clk);
        checks++;
        if (busy_valid !== 1'b1) begin
            failures++;
            $display("FAIL race_busy16 got busy=%b exp 1", busy_valid);
        end
        mem_resp_valid = 1'b1; mem_resp_data = 32'h80FF1234;
        @(negedge clk);
        idle_inputs();
        checks++;
        if ({regWEn, reg_dest, data, err_timeout} !== {1'b1, 5'd14, 32'h00000012, 1'b0}) begin
            failures++;
            $display("FAIL race_commit got we=%b dest=%0d data=%h err=%b exp 1/14/00000012/0",
                     regWEn, reg_dest, data, err_timeout);
        end
    endtask

    task automatic test_reset_mid_load();
        logic saw_we;
        saw_we = 1'b0;
        // leave a nonzero write port so an async clear is visible
        @(negedge clk);
        ex_valid = 1'b1; ex_is_load = 1'b0; ex_rd = 5'd21; ex_wen = 1'b1;
        ex_alu_result = 32'hCAFE_0001;
        @(negedge clk);
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd17; ex_wen = 1'b1;
        ex_funct3 = 3'b010;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({busy_valid, ex_ready, reg_dest, data, regWEn, busy_rd} !==
            {1'b0, 1'b1, 5'd0, 32'd0, 1'b0, 5'd0}) begin
            failures++;
            $display("FAIL rst_async got busy=%b rdy=%b dest=%0d data=%h we=%b brd=%0d exp 0/1/0/0/0/0",
                     busy_valid, ex_ready, reg_dest, data, regWEn, busy_rd);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        mem_resp_valid = 1'b1; mem_resp_data = 32'h7777_7777;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            idle_inputs();
            if (regWEn) saw_we = 1'b1;
        end
        checks++;
        if ({saw_we, data, busy_valid} !== {1'b0, 32'd0, 1'b0}) begin
            failures++;
            $display("FAIL rst_late_resp got we_seen=%b data=%h busy=%b exp 0/0/0",
                     saw_we, data, busy_valid);
        end
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_no_write();
        test_back_to_back();
        test_load_extract();
        test_load_latency();
        test_timeout();
        test_timeout_race();
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
Writeback stage that sits directly upstream of the register file and drives its write port (reg_dest, data, regWEn).
- Accepts completed results from execute over a valid/ready handshake.
- Waits for multi-cycle memory responses on loads, then performs load byte/halfword extraction with sign or zero extension.
- Registers the final write for exactly one cycle.
- Exports a same-cycle bypass and a pending-load indication so decode can avoid reading stale values from the register file.

Parameters:
TIMEOUT, 16, max WAIT_MEM cycles before a load is abandoned; legal range 2..255; internal counter width is 8 bits.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset; 0 = reset asserted
ex_valid  in  1  execute result valid
ex_ready  out  1  stage can accept a result
ex_rd  in  5  destination register
ex_wen  in  1  instruction writes rd
ex_is_load  in  1  result comes from memory
ex_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
ex_addr_lo  in  2  load address bits [1:0]
ex_alu_result  in  32  non-load write data
mem_resp_valid  in  1  memory response valid; single-cycle pulse
mem_resp_data  in  32  raw aligned memory word
reg_dest  out  5  regfile write index
data  out  32  regfile write data
regWEn  out  1  regfile write enable
byp_valid  out  1  bypass valid; equals regWEn
byp_rd  out  5  equals reg_dest
byp_data  out  32  equals data
busy_valid  out  1  a load is outstanding
busy_rd  out  5  rd of the outstanding load
err_timeout  out  1  sticky: a load timed out

Behaviour:
Reset (rst=0, asynchronous):
- state=IDLE, counter=0.
- reg_dest=0, data=0, regWEn=0, err_timeout=0, captured load fields=0.
- Holds while rst=0. This also applies mid-load: the outstanding load is dropped and no write occurs.

Output timing:
- All outputs except ex_ready, byp_* and busy_* are registered.
- ex_ready = (state==IDLE).
- busy_valid = (state==WAIT_MEM); busy_rd = captured rd.
- byp_* are combinational copies of the registered write port.

regWEn rules:
- regWEn is a one-cycle pulse.
- When regWEn=1, it equals captured wen AND (rd != 0). rd=0 never produces regWEn=1.
- Every cycle with no commit drives regWEn=0. reg_dest and data hold their last values.

IDLE state:
- Non-load accept (ex_valid & ~ex_is_load):
  - Next cycle: reg_dest=ex_rd, data=ex_alu_result, regWEn=ex_wen&(ex_rd!=0).
  - State stays IDLE. Latency 1 cycle; full throughput, back-to-back accepts allowed.
- Load accept (ex_valid & ex_is_load):
  - Capture rd, wen, funct3, addr_lo; counter=0; next state WAIT_MEM.
  - regWEn=0 next cycle.
- mem_resp_valid: ignored.

WAIT_MEM state:
- ex_ready=0; ex_valid is ignored.
- On mem_resp_valid:
  - Next cycle: reg_dest=rd, data=extract(mem_resp_data), regWEn=wen&(rd!=0).
  - Next state IDLE. A new result may be accepted the cycle after the commit.
- No response and counter==TIMEOUT-1:
  - err_timeout<=1, next state IDLE, no write.
  - WAIT_MEM therefore lasts exactly TIMEOUT cycles.
- No response otherwise: counter++.
- Response in the same cycle the timeout would fire: the response wins and err_timeout is unchanged.

Extraction:
- LB: byte at bit offset addr_lo*8, sign-extended.
- LBU: same byte, zero-extended.
- LH: halfword at offset addr_lo[1]*16, sign-extended; addr_lo[0] ignored.
- LHU: same halfword, zero-extended.
- LW: full word; addr_lo ignored.
- funct3 011, 110, 111: treated as LW.

err_timeout: cleared only by reset.

Test Plan:
- ALU write: ex_valid=1, is_load=0, rd=5, wen=1, result=0xDEADBEEF -> next cycle regWEn=1, reg_dest=5, data=0xDEADBEEF, byp_valid=1; following cycle regWEn=0.
- rd=0 / wen=0: ex_rd=0, wen=1, result=0x1234 -> regWEn stays 0 every cycle. Repeat with rd=7, wen=0 -> regWEn stays 0. Then back-to-back ALU results rd=1,2,3 on consecutive cycles -> three consecutive single-cycle writes in order.
- Load extraction with mem data 0x80FF1234, rd=9:
  - LB, addr_lo=3 -> 0xFFFFFF80
  - LBU, addr_lo=3 -> 0x00000080
  - LH, addr_lo=2 -> 0xFFFF80FF
  - LHU, addr_lo=0 -> 0x00001234
  - LW -> 0x80FF1234
- Load latency: load accepted at cycle 0, mem_resp_valid at cycle 3 -> ex_ready=0 and busy_valid=1, busy_rd=9 for cycles 1-3; regWEn=1 at cycle 4; ex_ready=1 at cycle 4.
- Timeout: TIMEOUT=16, no response -> busy_valid high exactly 16 cycles, then err_timeout=1 with no write. A response arriving exactly on the 16th cycle -> write occurs and err_timeout=0.
- Reset mid-load: drive rst=0 two cycles into WAIT_MEM -> outputs clear immediately, without waiting for a clock edge. A late mem_resp_valid after reset release -> ignored, no write.
